// File: rtl/jk_register_bank.sv
// Bank of WIDTH edge-triggered JK flip-flops, with modes for per-bit JK, T or D storage
// and for whole-word up/down counting. Clear and preset are synchronous.

module jk_bit_cell (
    input  logic [1:0] i_mode,
    input  logic       i_j,
    input  logic       i_k,
    input  logic       i_q,
    output logic       o_d
);
    always_comb begin
        o_d = i_q;
        case (i_mode)
            2'b00: begin
                case ({i_j, i_k})
                    2'b01:   o_d = 1'b0;
                    2'b10:   o_d = 1'b1;
                    2'b11:   o_d = ~i_q;
                    default: o_d = i_q;
                endcase
            end
            2'b01:   o_d = i_q ^ i_j;
            2'b10:   o_d = i_j;
            default: o_d = i_q; // COUNT mode is resolved at word level in the bank
        endcase
    end
endmodule

module jk_register_bank #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL = '1,
    parameter bit               WRAP       = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             up,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             tc
);
    typedef enum logic [1:0] {
        MODE_JK  = 2'b00,
        MODE_T   = 2'b01,
        MODE_D   = 2'b10,
        MODE_CNT = 2'b11
    } mode_e;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qbar;
    logic             r_tc;

    logic [WIDTH-1:0] w_bit_next;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_next;
    logic             w_at_limit;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        jk_bit_cell u_cell (
            .i_mode (mode),
            .i_j    (J[gi]),
            .i_k    (K[gi]),
            .i_q    (r_q[gi]),
            .o_d    (w_bit_next[gi])
        );
    end

    // At the limit, the count either wraps through the modular add or is held.
    always_comb begin
        w_at_limit = up ? (&r_q) : ~(|r_q);
        w_cnt_next = up ? (r_q + WIDTH'(1)) : (r_q - WIDTH'(1));
        if (!WRAP && w_at_limit)
            w_cnt_next = r_q;
        w_next = (mode_e'(mode) == MODE_CNT) ? w_cnt_next : w_bit_next;
    end

    // Qbar has its own register, so it never lags or skews relative to Q.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q    <= '0;
            r_qbar <= '1;
            r_tc   <= 1'b0;
        end else if (pr) begin
            r_q    <= PRESET_VAL;
            r_qbar <= ~PRESET_VAL;
            r_tc   <= 1'b0;
        end else if (en) begin
            r_q    <= w_next;
            r_qbar <= ~w_next;
            r_tc   <= (mode_e'(mode) == MODE_CNT) && w_at_limit;
        end else begin
            r_tc   <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign Qbar = r_qbar;
    assign tc   = r_tc;
endmodule

// File: tb/tb_jk_register_bank.sv
// Directed test of jk_register_bank: one wrapping instance and one saturating instance,
// both driven from the same inputs.

module tb_jk_register_bank;
    logic       clk = 1'b0;
    logic       clr, pr, en, up;
    logic [1:0] mode;
    logic [7:0] J, K;
    logic [7:0] q_w, qb_w, q_s, qb_s;
    logic       tc_w, tc_s;
    logic       armed = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    jk_register_bank #(.WIDTH(8), .PRESET_VAL(8'hFF), .WRAP(1'b1)) dut (
        .clk(clk), .clr(clr), .pr(pr), .en(en), .mode(mode), .up(up),
        .J(J), .K(K), .Q(q_w), .Qbar(qb_w), .tc(tc_w)
    );

    jk_register_bank #(.WIDTH(8), .PRESET_VAL(8'hFF), .WRAP(1'b0)) dut_s (
        .clk(clk), .clr(clr), .pr(pr), .en(en), .mode(mode), .up(up),
        .J(J), .K(K), .Q(q_s), .Qbar(qb_s), .tc(tc_s)
    );

    // Once the first clear has been clocked in, Qbar must track ~Q on every cycle.
    always @(negedge clk) begin
        if (armed) begin
            n_cmp++;
            if (qb_w !== ~q_w) begin
                n_err++;
                $display("FAIL qbar_wrap: Qbar=%h Q=%h want Qbar=%h", qb_w, q_w, ~q_w);
            end
            n_cmp++;
            if (qb_s !== ~q_s) begin
                n_err++;
                $display("FAIL qbar_sat: Qbar=%h Q=%h want Qbar=%h", qb_s, q_s, ~q_s);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; pr = 1'b1; en = 1'b1; mode = 2'b11; up = 1'b1; J = 8'h00; K = 8'h00;
        step();
        armed = 1'b1;
        n_cmp++; if (q_w !== 8'h00)  begin n_err++; $display("FAIL reset_q: got %h want 00", q_w); end
        n_cmp++; if (qb_w !== 8'hFF) begin n_err++; $display("FAIL reset_qbar: got %h want FF", qb_w); end
        n_cmp++; if (tc_w !== 1'b0)  begin n_err++; $display("FAIL reset_tc: got %b want 0", tc_w); end
        n_cmp++; if (q_s !== 8'h00)  begin n_err++; $display("FAIL reset_q_sat: got %h want 00", q_s); end
        clr = 1'b0; pr = 1'b0;
    endtask

    task automatic test_jk();
        mode = 2'b00; en = 1'b1;
        J = 8'hF0; K = 8'h0F; step();
        n_cmp++; if (q_w !== 8'hF0) begin n_err++; $display("FAIL jk_set_reset: got %h want F0", q_w); end
        J = 8'hFF; K = 8'hFF; step();
        n_cmp++; if (q_w !== 8'h0F) begin n_err++; $display("FAIL jk_toggle: got %h want 0F", q_w); end
        J = 8'h00; K = 8'h00; step();
        n_cmp++; if (q_w !== 8'h0F) begin n_err++; $display("FAIL jk_hold: got %h want 0F", q_w); end
        n_cmp++; if (tc_w !== 1'b0) begin n_err++; $display("FAIL jk_tc: got %b want 0", tc_w); end
    endtask

    task automatic test_t_d();
        mode = 2'b01; J = 8'h3C; K = 8'hFF; step();
        n_cmp++; if (q_w !== 8'h33) begin n_err++; $display("FAIL t_mode: got %h want 33", q_w); end
        mode = 2'b10; J = 8'hA5; K = 8'h00; step();
        n_cmp++; if (q_w !== 8'hA5) begin n_err++; $display("FAIL d_mode: got %h want A5", q_w); end
        en = 1'b0; J = 8'h00; step();
        n_cmp++; if (q_w !== 8'hA5) begin n_err++; $display("FAIL en_hold: got %h want A5", q_w); end
        en = 1'b1;
    endtask

    task automatic test_count_wrap();
        pr = 1'b1; step(); pr = 1'b0;
        n_cmp++; if (q_w !== 8'hFF) begin n_err++; $display("FAIL preset_q: got %h want FF", q_w); end
        n_cmp++; if (tc_w !== 1'b0) begin n_err++; $display("FAIL preset_tc: got %b want 0", tc_w); end
        mode = 2'b11; up = 1'b1; step();
        n_cmp++; if (q_w !== 8'h00) begin n_err++; $display("FAIL wrap_up_q: got %h want 00", q_w); end
        n_cmp++; if (tc_w !== 1'b1) begin n_err++; $display("FAIL wrap_up_tc: got %b want 1", tc_w); end
        step();
        n_cmp++; if (q_w !== 8'h01) begin n_err++; $display("FAIL cnt_up_q: got %h want 01", q_w); end
        n_cmp++; if (tc_w !== 1'b0) begin n_err++; $display("FAIL cnt_up_tc: got %b want 0", tc_w); end
        up = 1'b0; step();
        n_cmp++; if (q_w !== 8'h00) begin n_err++; $display("FAIL cnt_dn_q: got %h want 00", q_w); end
        n_cmp++; if (tc_w !== 1'b0) begin n_err++; $display("FAIL cnt_dn_tc: got %b want 0", tc_w); end
        step();
        n_cmp++; if (q_w !== 8'hFF) begin n_err++; $display("FAIL wrap_dn_q: got %h want FF", q_w); end
        n_cmp++; if (tc_w !== 1'b1) begin n_err++; $display("FAIL wrap_dn_tc: got %b want 1", tc_w); end
        step();
        n_cmp++; if (q_w !== 8'hFE) begin n_err++; $display("FAIL after_wrap_q: got %h want FE", q_w); end
        n_cmp++; if (tc_w !== 1'b0) begin n_err++; $display("FAIL tc_one_cycle: got %b want 0", tc_w); end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_q [3];
        logic       exp_tc[3];
        exp_q  = '{8'hFF, 8'hFF, 8'hFF};
        exp_tc = '{1'b0, 1'b1, 1'b1};
        mode = 2'b10; J = 8'hFE; step();
        n_cmp++; if (q_s !== 8'hFE) begin n_err++; $display("FAIL sat_load: got %h want FE", q_s); end
        mode = 2'b11; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (q_s !== exp_q[i])   begin n_err++; $display("FAIL sat_up_q[%0d]: got %h want %h", i, q_s, exp_q[i]); end
            n_cmp++; if (tc_s !== exp_tc[i]) begin n_err++; $display("FAIL sat_up_tc[%0d]: got %b want %b", i, tc_s, exp_tc[i]); end
        end
        en = 1'b0; step(); en = 1'b1;
        n_cmp++; if (q_s !== 8'hFF) begin n_err++; $display("FAIL sat_hold_q: got %h want FF", q_s); end
        n_cmp++; if (tc_s !== 1'b0) begin n_err++; $display("FAIL sat_hold_tc: got %b want 0", tc_s); end
        up = 1'b0; step();
        n_cmp++; if (q_s !== 8'hFE) begin n_err++; $display("FAIL sat_dn_q: got %h want FE", q_s); end
        n_cmp++; if (tc_s !== 1'b0) begin n_err++; $display("FAIL sat_dn_tc: got %b want 0", tc_s); end
    endtask

    task automatic test_reset_mid();
        clr = 1'b1; step(); clr = 1'b0;
        mode = 2'b11; up = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (q_w !== 8'h05) begin n_err++; $display("FAIL mid_count: got %h want 05", q_w); end
        clr = 1'b1; step(); clr = 1'b0;
        n_cmp++; if (q_w !== 8'h00) begin n_err++; $display("FAIL mid_clr_q: got %h want 00", q_w); end
        n_cmp++; if (tc_w !== 1'b0) begin n_err++; $display("FAIL mid_clr_tc: got %b want 0", tc_w); end
        step();
        n_cmp++; if (q_w !== 8'h01) begin n_err++; $display("FAIL resume: got %h want 01", q_w); end
        pr = 1'b1; clr = 1'b1; step(); pr = 1'b0; clr = 1'b0;
        n_cmp++; if (q_w !== 8'h00) begin n_err++; $display("FAIL clr_over_pr: got %h want 00", q_w); end
        n_cmp++; if (q_s !== 8'h00) begin n_err++; $display("FAIL clr_over_pr_sat: got %h want 00", q_s); end
    endtask

    task automatic test_back_to_back();
        // Preset then wrap on consecutive edges, then clear straight away: no tc may survive.
        mode = 2'b11; up = 1'b1; pr = 1'b1; step(); pr = 1'b0;
        step();
        n_cmp++; if (tc_w !== 1'b1) begin n_err++; $display("FAIL b2b_wrap_tc: got %b want 1", tc_w); end
        clr = 1'b1; step(); clr = 1'b0;
        n_cmp++; if (tc_w !== 1'b0) begin n_err++; $display("FAIL b2b_clr_tc: got %b want 0", tc_w); end
        n_cmp++; if (q_w !== 8'h00) begin n_err++; $display("FAIL b2b_clr_q: got %h want 00", q_w); end
    endtask

    initial begin
        clr = 1'b0; pr = 1'b0; en = 1'b0; up = 1'b0; mode = 2'b00; J = 8'h00; K = 8'h00;
        @(negedge clk);
        test_reset();
        test_jk();
        test_t_d();
        test_count_wrap();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
